// File: rtl/qlearn_pkg.sv
// Shared Q-learning table constants and the Q-max write controller state encoding.
package qlearn_pkg;
  localparam int Q_ADDR_W = 6;
  localparam int Q_DATA_W = 8;
  localparam int Q_DEPTH  = 64;

  typedef enum logic [1:0] {
    QM_CLEAR = 2'd0,
    QM_RUN   = 2'd1,
    QM_DRAIN = 2'd2
  } qmax_state_e;
endpackage

// File: rtl/qmax_fwd_cmp.sv
// Picks the freshest stored max for a state (in-flight write, last write, or BRAM)
// and flags whether the candidate beats it.
module qmax_fwd_cmp
  import qlearn_pkg::*;
#(
  parameter int ADDR_WIDTH = Q_ADDR_W,
  parameter int DATA_WIDTH = Q_DATA_W
) (
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] cand,
  input  logic [DATA_WIDTH-1:0] tbl_data,
  input  logic                  s2_vld,
  input  logic [ADDR_WIDTH-1:0] s2_addr,
  input  logic [DATA_WIDTH-1:0] s2_data,
  input  logic                  lw_vld,
  input  logic [ADDR_WIDTH-1:0] lw_addr,
  input  logic [DATA_WIDTH-1:0] lw_data,
  output logic                  wr
);
  logic [DATA_WIDTH-1:0] old_val;

  // The write on the port this cycle is newer than the one issued last cycle.
  always_comb begin
    old_val = tbl_data;
    if (lw_vld && lw_addr == rd_addr) old_val = lw_data;
    if (s2_vld && s2_addr == rd_addr) old_val = s2_data;
    wr = cand > old_val;
  end
endmodule

// File: rtl/qmax_updater.sv
// Q-max table write-side controller: read-compare-write of per-state maxima with
// forwarding, plus a zeroing sweep after reset or on request.
module qmax_updater
  import qlearn_pkg::*;
#(
  parameter int ADDR_WIDTH = Q_ADDR_W,
  parameter int DATA_WIDTH = Q_DATA_W,
  parameter int DEPTH      = Q_DEPTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [ADDR_WIDTH-1:0] i_state,
  input  logic [DATA_WIDTH-1:0] i_qval,
  output logic [ADDR_WIDTH-1:0] o_tbl_addr_r,
  input  logic [DATA_WIDTH-1:0] i_tbl_data,
  output logic                  o_tbl_we,
  output logic [ADDR_WIDTH-1:0] o_tbl_addr_w,
  output logic [DATA_WIDTH-1:0] o_tbl_data,
  output logic                  o_busy,
  output logic                  o_clr_done
);
  localparam int STAGES = 2;
  localparam int CW     = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] idx;
    logic [DATA_WIDTH-1:0] qval;
  } req_t;

  qmax_state_e           state;
  logic [CW-1:0]         cnt;
  logic [STAGES:1]       vld_pipe;
  req_t                  s1;
  logic                  lw_vld;
  logic [ADDR_WIDTH-1:0] lw_addr;
  logic [DATA_WIDTH-1:0] lw_data;
  logic                  accept;
  logic                  wr;

  assign o_ready      = (state == QM_RUN) && !i_clear;
  assign accept       = i_valid && o_ready;
  assign o_busy       = (state != QM_RUN);
  assign o_tbl_addr_r = (state == QM_RUN) ? i_state : cnt[ADDR_WIDTH-1:0];

  // Output write registers double as S2; the cycle after, they become the last-write entry.
  qmax_fwd_cmp #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_fwd (
    .rd_addr (s1.idx),
    .cand    (s1.qval),
    .tbl_data(i_tbl_data),
    .s2_vld  (o_tbl_we),
    .s2_addr (o_tbl_addr_w),
    .s2_data (o_tbl_data),
    .lw_vld  (lw_vld),
    .lw_addr (lw_addr),
    .lw_data (lw_data),
    .wr      (wr)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= QM_CLEAR;
      cnt          <= '0;
      vld_pipe     <= '0;
      s1           <= '0;
      lw_vld       <= 1'b0;
      lw_addr      <= '0;
      lw_data      <= '0;
      o_tbl_we     <= 1'b0;
      o_tbl_addr_w <= '0;
      o_tbl_data   <= '0;
      o_clr_done   <= 1'b0;
    end else begin
      vld_pipe   <= {vld_pipe[STAGES-1:1], accept};
      if (accept) s1 <= '{idx: i_state, qval: i_qval};
      // Sweep writes feed the last-write entry too, so the first update after a clear sees zero.
      lw_vld     <= o_tbl_we;
      lw_addr    <= o_tbl_addr_w;
      lw_data    <= o_tbl_data;
      o_clr_done <= 1'b0;
      case (state)
        QM_CLEAR: begin
          o_tbl_we     <= 1'b1;
          o_tbl_addr_w <= cnt[ADDR_WIDTH-1:0];
          o_tbl_data   <= '0;
          if (cnt == CNT_LAST) begin
            state      <= QM_RUN;
            cnt        <= '0;
            o_clr_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          o_tbl_we     <= vld_pipe[1] && wr;
          o_tbl_addr_w <= s1.idx;
          o_tbl_data   <= s1.qval;
          if (state == QM_RUN && i_clear) begin
            state <= QM_DRAIN;
          end else if (state == QM_DRAIN && vld_pipe == '0) begin
            state <= QM_CLEAR;
            cnt   <= '0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_qmax_updater.sv
// Directed bench for qmax_updater against a 1-cycle read-before-write BRAM model.
module tb_qmax_updater;
  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_clear = 1'b0;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic [5:0] i_state = '0;
  logic [7:0] i_qval = '0;
  logic [5:0] o_tbl_addr_r;
  logic [7:0] tbl_rd;
  logic       o_tbl_we;
  logic [5:0] o_tbl_addr_w;
  logic [7:0] o_tbl_data;
  logic       o_busy;
  logic       o_clr_done;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] mem [64];
  logic       seeded = 1'b0;

  always #5 i_clk = ~i_clk;

  qmax_updater dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clear     (i_clear),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_state     (i_state),
    .i_qval      (i_qval),
    .o_tbl_addr_r(o_tbl_addr_r),
    .i_tbl_data  (tbl_rd),
    .o_tbl_we    (o_tbl_we),
    .o_tbl_addr_w(o_tbl_addr_w),
    .o_tbl_data  (o_tbl_data),
    .o_busy      (o_busy),
    .o_clr_done  (o_clr_done)
  );

  // Table starts with junk so the clear sweep matters.
  always @(posedge i_clk) begin
    if (!seeded) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'hC3 ^ 8'(i);
      seeded <= 1'b1;
    end else begin
      tbl_rd <= mem[o_tbl_addr_r];
      if (o_tbl_we) mem[o_tbl_addr_w] <= o_tbl_data;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Caller is positioned at the negedge where the first sweep write should be visible.
  task automatic sweep_check(input int clr_at, input int n);
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge i_clk);
      i_clear = (k == clr_at);
      #1;
      chk("sweep_we", 32'(o_tbl_we), 1);
      chk("sweep_addr", 32'(o_tbl_addr_w), 32'(k));
      chk("sweep_data", 32'(o_tbl_data), 0);
      if (n == 64) begin
        chk("clr_done", 32'(o_clr_done), 32'(k == 63));
        chk("sweep_busy", 32'(o_busy), 32'(k != 63));
        chk("sweep_ready", 32'(o_ready), 32'(k == 63));
      end
    end
    i_clear = 1'b0;
  endtask

  task automatic wait_first_write(input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge i_clk);
      #1;
      if (o_tbl_we) seen = 1'b1;
    end
    chk("wait_sweep_start", 32'(seen), 1);
  endtask

  typedef struct {
    logic       v;
    logic [5:0] st;
    logic [7:0] qv;
    logic       we;
    logic [5:0] wa;
    logic [7:0] wd;
  } vec_t;

  vec_t vecs [29];

  initial begin
    // Expected write outputs lag the accepting cycle by two.
    vecs[0]  = '{1'b1, 6'd5,  8'd20,  1'b0, 6'd0,  8'd0};
    vecs[1]  = '{1'b1, 6'd5,  8'd10,  1'b0, 6'd0,  8'd0};
    vecs[2]  = '{1'b0, 6'd0,  8'd0,   1'b1, 6'd5,  8'd20};
    vecs[3]  = '{1'b0, 6'd0,  8'd0,   1'b0, 6'd0,  8'd0};
    vecs[4]  = '{1'b1, 6'd7,  8'd30,  1'b0, 6'd0,  8'd0};
    vecs[5]  = '{1'b1, 6'd7,  8'd40,  1'b0, 6'd0,  8'd0};
    vecs[6]  = '{1'b1, 6'd7,  8'd35,  1'b1, 6'd7,  8'd30};
    vecs[7]  = '{1'b0, 6'd0,  8'd0,   1'b1, 6'd7,  8'd40};
    vecs[8]  = '{1'b0, 6'd0,  8'd0,   1'b0, 6'd0,  8'd0};
    vecs[9]  = '{1'b1, 6'd9,  8'd50,  1'b0, 6'd0,  8'd0};
    vecs[10] = '{1'b0, 6'd0,  8'd0,   1'b0, 6'd0,  8'd0};
    vecs[11] = '{1'b1, 6'd9,  8'd45,  1'b1, 6'd9,  8'd50};
    vecs[12] = '{1'b0, 6'd0,  8'd0,   1'b0, 6'd0,  8'd0};
    vecs[13] = '{1'b1, 6'd9,  8'd50,  1'b0, 6'd0,  8'd0};
    vecs[14] = '{1'b0, 6'd0,  8'd0,   1'b0, 6'd0,  8'd0};
    vecs[15] = '{1'b0, 6'd0,  8'd0,   1'b0, 6'd0,  8'd0};
    vecs[16] = '{1'b1, 6'd9,  8'd51,  1'b0, 6'd0,  8'd0};
    vecs[17] = '{1'b0, 6'd0,  8'd0,   1'b0, 6'd0,  8'd0};
    vecs[18] = '{1'b0, 6'd0,  8'd0,   1'b1, 6'd9,  8'd51};
    vecs[19] = '{1'b1, 6'd63, 8'd255, 1'b0, 6'd0,  8'd0};
    vecs[20] = '{1'b1, 6'd0,  8'd1,   1'b0, 6'd0,  8'd0};
    vecs[21] = '{1'b0, 6'd0,  8'd0,   1'b1, 6'd63, 8'd255};
    vecs[22] = '{1'b0, 6'd0,  8'd0,   1'b1, 6'd0,  8'd1};
    vecs[23] = '{1'b0, 6'd0,  8'd0,   1'b0, 6'd0,  8'd0};
    vecs[24] = '{1'b1, 6'd5,  8'd21,  1'b0, 6'd0,  8'd0};
    vecs[25] = '{1'b1, 6'd7,  8'd39,  1'b0, 6'd0,  8'd0};
    vecs[26] = '{1'b0, 6'd0,  8'd0,   1'b1, 6'd5,  8'd21};
    vecs[27] = '{1'b0, 6'd0,  8'd0,   1'b0, 6'd0,  8'd0};
    vecs[28] = '{1'b0, 6'd0,  8'd0,   1'b0, 6'd0,  8'd0};

    // Reset state
    repeat (3) @(negedge i_clk);
    #1;
    chk("rst_we", 32'(o_tbl_we), 0);
    chk("rst_addr_w", 32'(o_tbl_addr_w), 0);
    chk("rst_data", 32'(o_tbl_data), 0);
    chk("rst_busy", 32'(o_busy), 1);
    chk("rst_ready", 32'(o_ready), 0);
    chk("rst_clr_done", 32'(o_clr_done), 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    sweep_check(10, 64);  // i_clear mid-sweep must be ignored

    // Table-driven update vectors
    for (int i = 0; i < 29; i++) begin
      @(negedge i_clk);
      i_valid = vecs[i].v;
      i_state = vecs[i].st;
      i_qval  = vecs[i].qv;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(o_ready), 1);
      chk($sformatf("v%0d_we", i), 32'(o_tbl_we), 32'(vecs[i].we));
      if (vecs[i].we) begin
        chk($sformatf("v%0d_addr", i), 32'(o_tbl_addr_w), 32'(vecs[i].wa));
        chk($sformatf("v%0d_data", i), 32'(o_tbl_data), 32'(vecs[i].wd));
      end
    end
    chk("mem9", 32'(mem[9]), 51);

    // Clear during a burst: in-flight writes finish, request with i_clear is refused
    @(negedge i_clk);
    i_valid = 1'b1; i_state = 6'd11; i_qval = 8'd5;
    #1 chk("burst0_ready", 32'(o_ready), 1);
    @(negedge i_clk);
    i_state = 6'd12; i_qval = 8'd6;
    #1 chk("burst1_ready", 32'(o_ready), 1);
    @(negedge i_clk);
    i_clear = 1'b1; i_state = 6'd13; i_qval = 8'd7;
    #1;
    chk("clr_ready", 32'(o_ready), 0);
    chk("clr_we0", 32'(o_tbl_we), 1);
    chk("clr_addr0", 32'(o_tbl_addr_w), 11);
    chk("clr_data0", 32'(o_tbl_data), 5);
    @(negedge i_clk);
    i_clear = 1'b0; i_valid = 1'b0;
    #1;
    chk("drain_we1", 32'(o_tbl_we), 1);
    chk("drain_addr1", 32'(o_tbl_addr_w), 12);
    chk("drain_data1", 32'(o_tbl_data), 6);
    chk("drain_busy", 32'(o_busy), 1);
    chk("drain_ready", 32'(o_ready), 0);
    wait_first_write(10);
    sweep_check(-1, 64);
    chk("mem5_cleared", 32'(mem[5]), 0);
    chk("mem13_cleared", 32'(mem[13]), 0);

    // Reset while an update is about to be written
    @(negedge i_clk);
    i_valid = 1'b1; i_state = 6'd20; i_qval = 8'd100;
    #1 chk("pre_rst_ready", 32'(o_ready), 1);
    @(negedge i_clk);
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    @(negedge i_clk);
    #1;
    chk("s2rst_we", 32'(o_tbl_we), 0);
    chk("s2rst_busy", 32'(o_busy), 1);
    chk("s2rst_ready", 32'(o_ready), 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    sweep_check(-1, 20);

    // Reset in the middle of a sweep restarts it at address 0
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1 chk("mid_addr", 32'(o_tbl_addr_w), 20);
    @(negedge i_clk);
    #1;
    chk("midrst_we", 32'(o_tbl_we), 0);
    chk("midrst_addr", 32'(o_tbl_addr_w), 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    sweep_check(-1, 64);
    @(negedge i_clk);
    #1;
    chk("final_ready", 32'(o_ready), 1);
    chk("final_we", 32'(o_tbl_we), 0);
    chk("mem20_zero", 32'(mem[20]), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
